// File: rtl/sc_bitstream_shifter_pkg.sv
// sc_bitstream_shifter_pkg: slow-control states and word-size constants shared with register preparation
package sc_bitstream_shifter_pkg;

    localparam int SC_BIT_NUM  = 616;
    localparam int SC_BYTE_NUM = SC_BIT_NUM / 8;

    typedef enum logic [2:0] {
        IDLE,
        RST_ASIC,
        FETCH,
        LATCH,
        SHIFT,
        LOAD,
        DONE
    } sc_state_t;

endpackage

// File: rtl/sc_clk_divider.sv
// sc_clk_divider: phase tick every CLK_DIV cycles while enabled, restarting from zero when disabled
module sc_clk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == LAST);

    // free-running phase counter, held at zero outside timed states
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_cnt <= '0;
        else     r_cnt <= (i_en && !o_tick) ? r_cnt + 1'b1 : '0;
    end

endmodule

// File: rtl/sc_bitstream_shifter.sv
// sc_bitstream_shifter: serialises the slow-control byte FIFO onto the ASIC shift-register pins
module sc_bitstream_shifter
    import sc_bitstream_shifter_pkg::*;
#(
    parameter int BIT_NUM      = SC_BIT_NUM,
    parameter int CLK_DIV      = 4,
    parameter int FIFO_TIMEOUT = 1024
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start_In,
    input  logic       Fifo_Empty,
    input  logic [7:0] Fifo_Dout,
    output logic       Fifo_Rd_En,
    output logic       Out_Sr_Ck,
    output logic       Out_Sr_In,
    output logic       Out_Sr_Rstb,
    output logic       Out_Load_Sc,
    output logic       Out_Busy,
    output logic       Out_Done,
    output logic       Out_Err
);

    localparam int TW = $clog2(FIFO_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(FIFO_TIMEOUT - 1);
    localparam logic [9:0] BITS = 10'(BIT_NUM);

    sc_state_t     r_state, w_next;
    logic          r_start_s, r_start_d, r_phase, r_err;
    logic          w_start, w_tick, w_div_en, w_half_done;
    logic [7:0]    r_sh;
    logic [9:0]    r_bit, w_bit_nx;
    logic [TW-1:0] r_to;

    assign w_start     = r_start_s & ~r_start_d;
    assign w_bit_nx    = r_bit + 10'd1;
    assign w_div_en    = r_state inside {RST_ASIC, SHIFT, LOAD};
    assign w_half_done = w_tick && r_phase;

    sc_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .Clk   (Clk),
        .Rst   (Rst),
        .i_en  (w_div_en),
        .o_tick(w_tick)
    );

    // state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next-state and pin decode; the ASIC pins are pure functions of state so reset clears them at once
    always_comb begin
        w_next      = r_state;
        Fifo_Rd_En  = (r_state == FETCH) && !Fifo_Empty;
        Out_Sr_Ck   = (r_state == SHIFT) && r_phase;
        Out_Sr_In   = (r_state == SHIFT) && r_sh[7];
        Out_Sr_Rstb = r_state != RST_ASIC;
        Out_Load_Sc = r_state == LOAD;
        Out_Busy    = !(r_state inside {IDLE, DONE});
        Out_Done    = r_state == DONE;
        Out_Err     = r_err;
        case (r_state)
            IDLE:     w_next = w_start ? RST_ASIC : IDLE;
            RST_ASIC: w_next = w_half_done ? FETCH : RST_ASIC;
            FETCH:    w_next = !Fifo_Empty ? LATCH : (r_to == TO_LAST) ? IDLE : FETCH;
            LATCH:    w_next = SHIFT;
            SHIFT:    w_next = (w_half_done && w_bit_nx[2:0] == 3'd0) ? ((w_bit_nx == BITS) ? LOAD : FETCH) : SHIFT;
            LOAD:     w_next = w_half_done ? DONE : LOAD;
            default:  w_next = IDLE;
        endcase
    end

    // start edge, phase, timeout, shift register and bit counter
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_start_s <= 1'b0;
            r_start_d <= 1'b0;
            r_phase   <= 1'b0;
            r_err     <= 1'b0;
            r_sh      <= '0;
            r_bit     <= '0;
            r_to      <= '0;
        end else begin
            r_start_s <= Start_In;
            r_start_d <= r_start_s;
            r_phase   <= w_tick ? ~r_phase : r_phase & w_div_en;
            if (r_state == IDLE && w_start) begin
                r_err <= 1'b0;
                r_bit <= '0;
                r_to  <= '0;
            end
            if (r_state == FETCH) begin
                r_to <= Fifo_Empty ? r_to + 1'b1 : '0;
                if (Fifo_Empty && r_to == TO_LAST) r_err <= 1'b1;
            end
            if (r_state == LATCH) r_sh <= Fifo_Dout;
            if (r_state == SHIFT && w_half_done) begin
                r_sh  <= {r_sh[6:0], 1'b0};
                r_bit <= w_bit_nx;
            end
        end
    end

endmodule

// File: tb/tb_sc_bitstream_shifter.sv
// tb_sc_bitstream_shifter: randomized loads checked against a bit-stream model of the expected ASIC traffic
module tb_sc_bitstream_shifter;

    localparam int BIT_NUM      = 616;
    localparam int CLK_DIV      = 4;
    localparam int FIFO_TIMEOUT = 1024;
    localparam int NBYTES       = BIT_NUM / 8;

    logic       clk = 0, rst = 1, start = 0, fifo_empty = 1;
    logic [7:0] fifo_dout = 0;
    logic       fifo_rd_en, out_sr_ck, out_sr_in, out_sr_rstb, out_load_sc, out_busy, out_done, out_err;

    int tests = 0, errs = 0, cyc = 0;
    logic [7:0] q[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] tmp_byte, first8;

    int nrise, load_len, load_pulses, low_run, rstb_len, rstb_entries, done_cnt;
    int last_fall, done_cyc, err_cyc, rstb_fall_cyc, c0, expb;
    logic done_seen, err_seen, held, prev_ck, prev_in, prev_load, prev_rstb, prev_err, ck_quiet;

    sc_bitstream_shifter #(.BIT_NUM(BIT_NUM), .CLK_DIV(CLK_DIV), .FIFO_TIMEOUT(FIFO_TIMEOUT)) dut (
        .Clk(clk), .Rst(rst), .Start_In(start), .Fifo_Empty(fifo_empty), .Fifo_Dout(fifo_dout),
        .Fifo_Rd_En(fifo_rd_en), .Out_Sr_Ck(out_sr_ck), .Out_Sr_In(out_sr_in), .Out_Sr_Rstb(out_sr_rstb),
        .Out_Load_Sc(out_load_sc), .Out_Busy(out_busy), .Out_Done(out_done), .Out_Err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not end, errs=%0d", errs);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        tests++;
        if (act !== 32'(exp)) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // standard-read FIFO: data appears the clock after the read strobe
    always @(posedge clk) begin
        if (fifo_rd_en && q.size() > 0) fifo_dout <= q.pop_front();
        #2 fifo_empty = (q.size() == 0);
    end

    // bit-level observer of the ASIC pins against the expected byte stream
    always @(negedge clk) begin
        if (rst) begin
            prev_ck = 0; prev_in = 0; prev_load = 0; prev_rstb = 1; prev_err = 0; low_run = 0; rstb_len = 0;
        end else begin
            if (fifo_rd_en || out_load_sc || !out_sr_rstb || !out_busy)
                chk("ck_low_outside_shift", out_sr_ck, 0);
            if (out_sr_ck && !prev_ck) begin
                if ((nrise >> 3) < exp_bytes.size()) begin
                    tmp_byte = exp_bytes[nrise >> 3];
                    expb = int'(tmp_byte[7 - (nrise & 7)]);
                end else expb = 2;
                chk($sformatf("bit%0d", nrise), out_sr_in, expb);
                chk("setup_before_rise", low_run >= CLK_DIV, 1);
                if (nrise < 8) first8 = {first8[6:0], out_sr_in};
                held = out_sr_in;
                nrise++;
            end else if (out_sr_ck && prev_ck) chk("hold_high_phase", out_sr_in, int'(held));
            low_run = out_sr_ck ? 0 : (out_sr_in == prev_in) ? low_run + 1 : 1;
            if (!out_sr_ck && prev_ck) last_fall = cyc;
            if (out_load_sc) begin
                load_len++;
                chk("load_sr_in", out_sr_in, 0);
            end else if (prev_load) begin
                load_pulses++;
                chk("load_len", load_len, 2 * CLK_DIV);
                chk("load_after_bits", nrise, BIT_NUM);
                load_len = 0;
            end
            if (out_done) begin
                done_seen = 1; done_cnt++; done_cyc = cyc;
                chk("done_busy_low", out_busy, 0);
                chk("done_bits", nrise, BIT_NUM);
                chk("done_one_load", load_pulses, 1);
            end
            if (!out_sr_rstb) rstb_len++;
            if (!out_sr_rstb && prev_rstb) begin rstb_entries++; rstb_fall_cyc = cyc; end
            if (out_sr_rstb && !prev_rstb) begin chk("rstb_len", rstb_len, 2 * CLK_DIV); rstb_len = 0; end
            if (out_err && !prev_err) begin err_seen = 1; err_cyc = cyc; end
            prev_ck = out_sr_ck; prev_in = out_sr_in; prev_load = out_load_sc;
            prev_rstb = out_sr_rstb; prev_err = out_err;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic new_load();
        nrise = 0; load_len = 0; load_pulses = 0; first8 = 0;
        done_seen = 0; err_seen = 0;
        exp_bytes.delete();
    endtask

    task automatic fill(input int n, input int first, input bit to_fifo);
        for (int i = 0; i < n; i++) begin
            tmp_byte = (i == 0 && first >= 0) ? 8'(first) : 8'($urandom_range(0, 255));
            exp_bytes.push_back(tmp_byte);
            if (to_fifo) q.push_back(tmp_byte);
        end
    endtask

    task automatic fire_start();
        @(posedge clk);
        #1;
        start = 1;
        c0 = cyc;
    endtask

    task automatic wait_end(input int bound);
        int n = 0;
        while (!done_seen && !err_seen && n < bound) begin step(1); n++; end
        chk("end_reached", done_seen || err_seen, 1);
    endtask

    task automatic chk_reset(input string name);
        chk(name, {fifo_rd_en, out_sr_ck, out_sr_in, out_sr_rstb, out_load_sc, out_busy, out_done, out_err}, 8'b0001_0000);
    endtask

    initial begin
        int r0, d0;
        step(3);
        chk_reset("reset_values");
        rst = 0;
        step(3);

        // full load with one surplus byte that must stay in the FIFO
        new_load();
        fill(NBYTES + 1, 8'hF3, 1);
        fire_start();
        wait_end(7000);
        chk("start_to_rstb", rstb_fall_cyc - c0, 2);
        chk("rst_to_done_cycles", done_cyc - rstb_fall_cyc + 1, 5099);
        chk("first_byte_bits", first8, 8'hF3);
        chk("rises_total", nrise, BIT_NUM);
        chk("surplus_unread", q.size(), 1);
        chk("full_err", out_err, 0);
        start = 0; q.delete(); step(4);

        // trickled bytes with long empty gaps
        new_load();
        fill(NBYTES, -1, 0);
        ck_quiet = 1;
        fire_start();
        for (int i = 0; i < NBYTES; i++) begin
            q.push_back(exp_bytes[i]);
            step(100);
            for (int j = 0; j < 100; j++) begin
                if (out_sr_ck) ck_quiet = 0;
                step(1);
            end
        end
        wait_end(300);
        chk("trickle_done", done_seen, 1);
        chk("trickle_err", out_err, 0);
        chk("trickle_ck_quiet", ck_quiet, 1);
        chk("trickle_rises", nrise, BIT_NUM);
        start = 0; step(4);

        // underrun after 40 bytes, then a clean load clears the flag
        new_load();
        fill(40, -1, 1);
        fire_start();
        wait_end(40 * 66 + FIFO_TIMEOUT + 200);
        chk("underrun_err", err_seen, 1);
        chk("underrun_delay", err_cyc - last_fall, FIFO_TIMEOUT);
        chk("underrun_busy", out_busy, 0);
        chk("underrun_no_load", load_pulses, 0);
        chk("underrun_no_done", done_seen, 0);
        chk("underrun_rises", nrise, 320);
        start = 0; step(4);
        new_load();
        fill(NBYTES, -1, 1);
        fire_start();
        step(3);
        chk("err_cleared", out_err, 0);
        wait_end(7000);
        chk("after_err_done", done_seen, 1);
        chk("after_err_rises", nrise, BIT_NUM);
        start = 0; step(4);

        // start held high and re-pulsed while busy: one load only
        new_load();
        fill(NBYTES + 1, -1, 1);
        r0 = rstb_entries; d0 = done_cnt;
        fire_start();
        step(1000);
        start = 0; step(3); start = 1;
        wait_end(7000);
        step(200);
        chk("held_one_rst", rstb_entries - r0, 1);
        chk("held_one_done", done_cnt - d0, 1);
        chk("held_surplus", q.size(), 1);
        chk("held_idle", out_busy, 0);
        start = 0; q.delete(); step(4);

        // asynchronous reset in the middle of a load, then a clean reload
        new_load();
        fill(NBYTES, -1, 1);
        fire_start();
        for (int n = 0; n < 7000 && nrise < 300; n++) step(1);
        chk("reached_bit300", nrise >= 300, 1);
        #2 rst = 1;
        #1 chk_reset("midload_reset");
        start = 0; q.delete();
        step(3);
        rst = 0;
        step(3);
        chk_reset("after_reset_release");
        new_load();
        fill(NBYTES, -1, 1);
        fire_start();
        wait_end(7000);
        chk("reload_start_lat", rstb_fall_cyc - c0, 2);
        chk("reload_done", done_seen, 1);
        chk("reload_rises", nrise, BIT_NUM);
        chk("reload_err", out_err, 0);
        start = 0; step(4);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule

// File: doc/sc_bitstream_shifter.md
# sc_bitstream_shifter

Downstream consumer of the slow-control byte FIFO filled by the register-preparation stage. It fetches the 77 bytes of the 616-bit ASIC configuration word MSB-first, serialises them onto the ASIC slow-control shift-register pins at a divided clock, and then pulses the load strobe. It reports completion or FIFO underrun to the control FSM.

## Interface
Parameters:
- BIT_NUM, 616: configuration bits per load; must be a multiple of 8.
- CLK_DIV, 4: Clk cycles per half-period of Out_Sr_Ck; minimum 2.
- FIFO_TIMEOUT, 1024: Clk cycles to wait on an empty FIFO before declaring underrun.

Ports:
- Clk, input, 1: system clock; the only clock.
- Rst, input, 1: asynchronous, active-high reset.
- Start_In, input, 1: level from control; a rising edge starts one load.
- Fifo_Empty, input, 1: slow-control FIFO empty flag.
- Fifo_Dout, input, 8: FIFO read data; valid one Clk after Fifo_Rd_En (standard, not FWFT).
- Fifo_Rd_En, output, 1: one-cycle read strobe.
- Out_Sr_Ck, output, 1: ASIC shift clock.
- Out_Sr_In, output, 1: ASIC serial data.
- Out_Sr_Rstb, output, 1: ASIC shift-register reset, active-low.
- Out_Load_Sc, output, 1: ASIC load strobe.
- Out_Busy, output, 1: high while a load is in progress.
- Out_Done, output, 1: one-cycle pulse on successful completion.
- Out_Err, output, 1: sticky underrun flag; cleared by the next accepted start.

## Operation
- Reset values:
  - Fifo_Rd_En, Out_Sr_Ck, Out_Sr_In, Out_Load_Sc, Out_Busy, Out_Done, Out_Err = 0.
  - Out_Sr_Rstb = 1.
  - State = IDLE.
- Start detection: Start_In is registered once; start = Start_In & ~Start_In_d. A start edge is ignored unless the state is IDLE.
- IDLE: on start, clear Out_Err, set Out_Busy, go to RST_ASIC.
- RST_ASIC: drive Out_Sr_Rstb low for 2*CLK_DIV cycles, then release it and go to FETCH.
- FETCH:
  - If !Fifo_Empty: pulse Fifo_Rd_En for 1 cycle and go to LATCH.
  - Otherwise increment the timeout counter. When it reaches FIFO_TIMEOUT, set Out_Err, clear Out_Busy, go to IDLE.
  - The timeout counter resets on every successful read.
- LATCH: capture Fifo_Dout into an 8-bit shift register and go to SHIFT.
- SHIFT: for each of 8 bits, MSB first:
  - Low phase: Out_Sr_In = shreg[7] and Out_Sr_Ck = 0 for CLK_DIV cycles.
  - High phase: Out_Sr_Ck = 1 for CLK_DIV cycles.
  - Then shift shreg left by 1 and increment the bit counter.
- After 8 bits:
  - bit counter < BIT_NUM: go to FETCH.
  - bit counter = BIT_NUM: go to LOAD.
- LOAD: Out_Sr_Ck = 0, Out_Sr_In = 0, Out_Load_Sc = 1 for 2*CLK_DIV cycles, then go to DONE.
- DONE: pulse Out_Done for 1 cycle, clear Out_Busy, go to IDLE.
- Bit counter width is 10 bits (covers 616). Divider counter width is clog2(CLK_DIV). Timeout counter width is clog2(FIFO_TIMEOUT+1).
- Reset mid-operation: all outputs return to their reset values asynchronously. Bytes already read are not recovered; upstream flushes the FIFO before restarting.
- Extra FIFO bytes beyond BIT_NUM/8 are never read.

## Timing
- Start edge to first cycle with Out_Sr_Rstb low: 2 Clk. This is 1 cycle for the edge register plus 1 cycle for the state register.
- Out_Sr_In is stable for CLK_DIV cycles before each Out_Sr_Ck rise and holds through the high phase.
- Per byte with the FIFO never empty: 2 cycles (FETCH and LATCH) + 16*CLK_DIV cycles of shifting.
- Total with defaults (FIFO never empty), from the first cycle in RST_ASIC to the Out_Done pulse: 8 + 77*66 + 8 + 1 = 5099 cycles.
- Out_Busy falls in the same cycle that Out_Done is high.
- Out_Sr_Ck is always 0 outside SHIFT, and 0 whenever Fifo_Rd_En is high.

## Structure
- Shared slow-control package holds:
  - the state enum (IDLE, RST_ASIC, FETCH, LATCH, SHIFT, LOAD, DONE);
  - the constants SC_BIT_NUM = 616 and SC_BYTE_NUM = 77, shared with the register-preparation stage.
- One natural sub-module: sc_clk_divider.
  - Generates a phase-tick every CLK_DIV cycles.
  - Enabled only in SHIFT, RST_ASIC and LOAD.
  - The FSM owns Out_Sr_Ck.
- Everything else is a single FSM plus datapath in this module.

## Test plan
- Full load, FIFO preloaded with 77 bytes, first byte 8'hF3:
  - first 8 Out_Sr_In values sampled on Out_Sr_Ck rises are 1,1,1,1,0,0,1,1;
  - 616 rising edges total, then Out_Load_Sc high for 8 cycles;
  - Out_Done at cycle 5099 after RST_ASIC entry.
- Bytes trickled in every 200 cycles: all 616 bits are correct, Out_Err = 0, and Out_Sr_Ck holds 0 during the waits.
- FIFO holds only 40 bytes: Out_Err rises 1024 cycles after byte 40 is consumed, Out_Busy falls, and there is no Out_Load_Sc pulse. A subsequent start clears Out_Err.
- Start_In held high, or pulsed again while busy: exactly one load; the second edge is ignored.
- Rst asserted at bit 300: all outputs go immediately to reset values with Out_Sr_Rstb = 1. After reset release, a flushed-and-refilled FIFO plus a start gives a clean 616-bit load.
